// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: one-to-N stream demux with unicast, broadcast, and out-of-range drop accounting
module demux_1xn_stream #(
  parameter int DATA_W = 8,
  parameter int N_OUT = 4,
  localparam int SEL_W = N_OUT > 2 ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    bcast,
  output logic [N_OUT*DATA_W-1:0] dout,
  output logic [N_OUT-1:0]        dout_valid,
  input  logic [N_OUT-1:0]        dout_ready,
  output logic                    drop_pulse,
  output logic [7:0]              drop_cnt
);
  logic [N_OUT-1:0][DATA_W-1:0] data;
  logic [N_OUT-1:0] can, hit, wr;
  logic acc, drop;
  for (genvar i = 0; i < N_OUT; i++) begin : g_hit
    assign hit[i] = sel == SEL_W'(i);
  end
  assign can = ~dout_valid | dout_ready;
  // no hit means sel is out of range: always accepted, then discarded
  assign din_ready = !rst && (bcast ? &can : (|(hit & can) || !(|hit)));
  assign acc = din_valid && din_ready;
  assign wr = acc ? (bcast ? {N_OUT{1'b1}} : hit) : '0;
  assign drop = acc && !bcast && !(|hit);
  assign dout = data;
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      dout_valid <= '0;
      drop_pulse <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (wr[k]) data[k] <= din;
        dout_valid[k] <= wr[k] | (dout_valid[k] & ~dout_ready[k]);
      end
      drop_pulse <= drop;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb_demux_1xn_stream: randomized scoreboard bench; per-channel queues model the expected words
module tb_demux_1xn_stream;
  localparam int DW = 8;
  localparam int N = 5;
  localparam int SW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic bcast = 1'b0;
  logic [DW-1:0] din = '0;
  logic [SW-1:0] sel = '0;
  logic [N-1:0] dout_ready = '1;
  logic din_ready, drop_pulse;
  logic [N*DW-1:0] dout;
  logic [N-1:0] dout_valid;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  int drops = 0;
  logic exp_pulse = 1'b0;
  logic [DW-1:0] q[N][$];

  demux_1xn_stream #(.DATA_W(DW), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sel(sel), .bcast(bcast), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any valid lane must show the oldest expected word; a transfer retires it
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < N; k++) begin
        if (dout_valid[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("spurious_valid_ch%0d", k), 64'(dout_valid[k]), 64'd0);
          end else begin
            chk($sformatf("lane_ch%0d", k), 64'(dout[k*DW +: DW]), 64'(q[k][0]));
            if (dout_ready[k]) void'(q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic bc, input logic [SW-1:0] s,
                      input logic [DW-1:0] d, input logic [N-1:0] rdy);
    logic exp_rdy, all_ok;
    @(posedge clk);
    #1;
    chk("drop_pulse", 64'(drop_pulse), 64'(exp_pulse));
    chk("drop_cnt", 64'(drop_cnt), 64'(drops > 255 ? 255 : drops));
    din_valid = v;
    bcast = bc;
    sel = s;
    din = d;
    dout_ready = rdy;
    #1;
    all_ok = 1'b1;
    for (int k = 0; k < N; k++) if (q[k].size() != 0 && !rdy[k]) all_ok = 1'b0;
    exp_rdy = bc ? all_ok : (int'(s) < N ? (q[s].size() == 0 || rdy[s]) : 1'b1);
    chk("din_ready", 64'(din_ready), 64'(exp_rdy));
    exp_pulse = 1'b0;
    if (v && exp_rdy) begin
      if (bc) for (int k = 0; k < N; k++) q[k].push_back(d);
      else if (int'(s) < N) q[s].push_back(d);
      else begin
        drops++;
        exp_pulse = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    din_valid = 1'b1;
    bcast = 1'b0;
    sel = '0;
    din = '1;
    dout_ready = '1;
    #1;
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din_ready2", 64'(din_ready), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    for (int k = 0; k < N; k++) q[k].delete();
    drops = 0;
    exp_pulse = 1'b0;
    rst = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    for (int s = 0; s < N; s++) step(1'b1, 1'b0, SW'(s), DW'(8'hA0 + s), '1);
    step(1'b0, 1'b0, '0, '0, '1);
    step(1'b1, 1'b0, 3'd2, 8'h55, 5'b11011);
    step(1'b1, 1'b0, 3'd2, 8'h66, 5'b11011);
    step(1'b1, 1'b0, 3'd2, 8'h66, 5'b11011);
    chk("bp_hold", 64'(dout[2*DW +: DW]), 64'h55);
    chk("bp_valid", 64'(dout_valid[2]), 64'd1);
    step(1'b1, 1'b0, 3'd2, 8'h66, '1);
    step(1'b0, 1'b0, '0, '0, '1);
    chk("bp_refill", 64'(dout[2*DW +: DW]), 64'h66);
    step(1'b1, 1'b0, 3'd2, 8'h77, 5'b11011);
    step(1'b1, 1'b1, '0, 8'hC3, 5'b11011);
    step(1'b1, 1'b1, '0, 8'hC3, '1);
    step(1'b0, 1'b0, '0, '0, '1);
    chk("bcast_valid", 64'(dout_valid), 64'h1f);
    for (int k = 0; k < N; k++) chk($sformatf("bcast_lane%0d", k), 64'(dout[k*DW +: DW]), 64'hC3);
    repeat (300) step(1'b1, 1'b0, 3'd7, DW'($urandom), '1);
    step(1'b0, 1'b0, '0, '0, '1);
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    chk("drop_no_valid", 64'(dout_valid), 64'd0);
    repeat (20) step(1'b1, 1'($urandom_range(0, 3) == 0), SW'($urandom_range(0, 7)),
                     DW'($urandom), N'($urandom));
    do_reset();
    repeat (3000) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                       SW'($urandom_range(0, 7)), DW'($urandom),
                       N'($urandom) | N'($urandom));
    repeat (3) step(1'b0, 1'b0, '0, '0, '1);
    for (int k = 0; k < N; k++) chk($sformatf("drained_ch%0d", k), 64'(q[k].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
